uart_rx_fifo: RTL
=================

Name: uart_rx_fifo

Overview:
Parametrised UART receiver for the serial peripheral path.
- Oversamples rxd with an externally generated tick and samples each bit at mid-bit.
- Supports configurable data width, optional even/odd parity and 1 or 2 stop bits.
- Buffers received characters in a first-word-fall-through FIFO.
- Reports framing, parity and overrun errors as sticky flags cleared by software.

Parameters:
- DATA_BITS, 8: data bits per character, legal 5..9, LSB first on the line.
- OVERSAMPLE, 16: sample_tick pulses per bit period; even, at least 4.
- PARITY_EN, 0: 1 = a parity bit follows the data bits.
- PARITY_ODD, 0: 0 = even parity, 1 = odd; ignored when PARITY_EN = 0.
- STOP_BITS, 1: 1 or 2.
- FIFO_DEPTH, 4: receive FIFO entries; power of two, at least 2.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- rxd  in  1  asynchronous serial input, idle high
- sample_tick  in  1  one-clk pulse at OVERSAMPLE x baud rate
- rd_en  in  1  pop FIFO head; ignored when rx_empty = 1
- rd_data  out  DATA_BITS  FIFO head; valid while rx_empty = 0
- rx_empty  out  1  FIFO empty
- rx_count  out  $clog2(FIFO_DEPTH+1)  number of entries in the FIFO
- rx_busy  out  1  high while the FSM is not in IDLE
- err_clr  in  1  clears all three error flags
- frame_err  out  1  sticky framing error
- parity_err  out  1  sticky parity error
- overrun  out  1  sticky overrun (character dropped, FIFO full)

Behaviour:

Synchroniser
- rxd passes through 2 flops, both reset to 1. rxd_s is the second flop.
- All FSM decisions use rxd_s.

Reset values
- rd_data = 0, rx_empty = 1, rx_count = 0, rx_busy = 0, all error flags = 0.
- FSM in IDLE, tick counter and bit index cleared.
- Reset mid-frame discards the partial character. No flag is set.

Counters
- tick_cnt advances only on cycles where sample_tick = 1.
- Every state entry clears tick_cnt.
- bit_idx counts data bits received.

FSM: IDLE, START, DATA, PARITY, STOP
- IDLE: rxd_s = 0 -> START. Moves on the clk edge; does not wait for a tick.
- START: on the tick where tick_cnt == OVERSAMPLE/2-1, rxd_s is checked.
  - rxd_s = 0 -> DATA, bit_idx = 0.
  - rxd_s = 1 -> IDLE. This is a glitch reject; no flag is set.
- DATA: on the tick where tick_cnt == OVERSAMPLE-1, rxd_s shifts into the shift register MSB (right shift) and bit_idx increments.
  - After the sample with bit_idx == DATA_BITS-1: go to PARITY if PARITY_EN = 1, otherwise STOP.
- PARITY: sample on the same tick position as DATA.
  - Even mode: error if XOR(data, parity bit) != 0.
  - Odd mode: error if XOR(data, parity bit) != 1.
  - Go to STOP.
- STOP: sample on the same tick position as DATA.
  - Any stop sample = 0 is a framing error.
  - STOP_BITS = 2: both stop bits are sampled.
  - After the last stop sample -> IDLE. The FSM returns at mid-stop-bit so it can resync on back-to-back frames.

Completion (evaluated on the clk of the last stop sample)
- Framing or parity error: the character is discarded and the matching flag is set. Both flags can set together.
- Otherwise, FIFO not full, or full with rd_en = 1 in the same cycle: push. The entry appears on the next clk, when rx_empty falls and rx_count increments.
- Otherwise (FIFO full, no pop): the character is dropped and overrun is set. FIFO contents are unchanged.

FIFO
- Read is first-word fall-through: rd_data always shows the head entry.
- rd_en pops on the clk edge and rd_data updates the next cycle.
- Simultaneous push and pop: rx_count is unchanged and order is preserved.
- Pointers wrap modulo FIFO_DEPTH.
- rd_en while empty has no effect. rx_count never underflows.

Error flags
- Sticky until err_clr = 1.
- If err_clr and a new error occur in the same cycle, the flag ends set.

Other
- rx_busy = 1 whenever state != IDLE.
- sample_tick stuck low freezes the FSM mid-frame. It resumes when ticks resume.

Test Plan:
1. Defaults, frame 0x55 (start, 10101010 LSB first, stop) at OVERSAMPLE=16 -> rx_empty falls one clk after the stop sample tick, rd_data = 0x55, rx_count = 1, no error flags.
2. Low pulse of 6 ticks on rxd while IDLE -> FSM returns to IDLE after the START check, rx_empty stays 1, no flags set.
3. PARITY_EN=1, PARITY_ODD=0: send 0xA3 with parity 0 (correct) then 0xA3 with parity 1 -> first character stored; second discarded with parity_err = 1, rx_count = 1.
4. STOP_BITS=2: send 0x3C with second stop bit = 0 -> frame_err = 1, FIFO empty. Then err_clr = 1 -> frame_err = 0.
5. FIFO_DEPTH=4: send 5 characters 0x01..0x05 with no reads -> rx_count = 4, overrun = 1. Reads return 0x01, 0x02, 0x03, 0x04, then rx_empty = 1.
6. FIFO full, rd_en asserted on the completion clk of a 5th character 0x66 -> rx_count stays 4, overrun = 0, 0x66 is read last. Additionally, asserting rst_n = 0 mid-DATA leaves all outputs at reset values and the next frame is received correctly.

Source files
------------

// File: rtl/uart_rx_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : uart_rx_fifo
//  Purpose  : Oversampling UART receiver.
//             - Two-flop input synchroniser.
//             - Mid-bit sampling FSM with optional parity and 1/2 stop bits.
//             - First-word-fall-through receive FIFO.
//             - Sticky framing, parity and overrun flags.
//  Revision : 1.0 - initial release
// ============================================================================
module uart_rx_fifo #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              rxd,
    input  logic                              sample_tick,
    input  logic                              rd_en,
    output logic [DATA_BITS-1:0]              rd_data,
    output logic                              rx_empty,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   rx_count,
    output logic                              rx_busy,
    input  logic                              err_clr,
    output logic                              frame_err,
    output logic                              parity_err,
    output logic                              overrun
);

    localparam int CNT_W = $clog2(OVERSAMPLE);
    localparam int BIT_W = $clog2(DATA_BITS);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CW    = $clog2(FIFO_DEPTH + 1);

    localparam logic [CNT_W-1:0] c_tick_mid  = CNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [CNT_W-1:0] c_tick_end  = CNT_W'(OVERSAMPLE - 1);
    localparam logic [BIT_W-1:0] c_last_bit  = BIT_W'(DATA_BITS - 1);
    localparam logic [CW-1:0]    c_full_cnt  = CW'(FIFO_DEPTH);
    localparam logic             c_par_odd   = (PARITY_ODD != 0);
    localparam logic             c_par_en    = (PARITY_EN != 0);
    localparam logic             c_two_stop  = (STOP_BITS == 2);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    // ------------------------------------------------------------------
    // Signals
    // ------------------------------------------------------------------
    logic                   rxd_meta_q;
    logic                   rxd_s_q;

    state_t                 state_q,    state_d;
    logic [CNT_W-1:0]       tick_cnt_q, tick_cnt_d;
    logic [BIT_W-1:0]       bit_idx_q,  bit_idx_d;
    logic [DATA_BITS-1:0]   shift_q,    shift_d;
    logic                   perr_q,     perr_d;
    logic                   ferr_q,     ferr_d;
    logic                   stop_idx_q, stop_idx_d;

    logic                   done;
    logic                   done_ferr;
    logic                   done_perr;
    logic                   tick_mid;
    logic                   tick_end;

    logic [DATA_BITS-1:0]   mem_q [FIFO_DEPTH];
    logic [DATA_BITS-1:0]   mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0]       wr_ptr_q,   wr_ptr_d;
    logic [PTR_W-1:0]       rd_ptr_q,   rd_ptr_d;
    logic [CW-1:0]          count_q,    count_d;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic                   push;
    logic                   pop;
    logic                   good_char;

    logic                   frame_err_q,  frame_err_d;
    logic                   parity_err_q, parity_err_d;
    logic                   overrun_q,    overrun_d;

    // Two-flop synchroniser; idles high like the line itself
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rxd_meta_q <= 1'b1;
            rxd_s_q    <= 1'b1;
        end else begin
            rxd_meta_q <= rxd;
            rxd_s_q    <= rxd_meta_q;
        end
    end

    assign tick_mid = sample_tick && (tick_cnt_q == c_tick_mid);
    assign tick_end = sample_tick && (tick_cnt_q == c_tick_end);

    // Receiver FSM: next state, counters, shift register and completion
    always_comb begin
        state_d    = state_q;
        tick_cnt_d = tick_cnt_q;
        bit_idx_d  = bit_idx_q;
        shift_d    = shift_q;
        perr_d     = perr_q;
        ferr_d     = ferr_q;
        stop_idx_d = stop_idx_q;
        done       = 1'b0;
        done_ferr  = 1'b0;
        done_perr  = 1'b0;

        if (sample_tick && state_q != S_IDLE) begin
            tick_cnt_d = tick_cnt_q + CNT_W'(1);
        end

        case (state_q)
            S_IDLE: begin
                tick_cnt_d = '0;
                bit_idx_d  = '0;
                if (!rxd_s_q) begin
                    state_d    = S_START;
                    perr_d     = 1'b0;
                    ferr_d     = 1'b0;
                    stop_idx_d = 1'b0;
                end
            end

            S_START: begin
                if (tick_mid) begin
                    tick_cnt_d = '0;
                    bit_idx_d  = '0;
                    // A high line at mid-start is a glitch, not a character
                    state_d    = rxd_s_q ? S_IDLE : S_DATA;
                end
            end

            S_DATA: begin
                if (tick_end) begin
                    tick_cnt_d = '0;
                    shift_d    = {rxd_s_q, shift_q[DATA_BITS-1:1]};
                    bit_idx_d  = bit_idx_q + BIT_W'(1);
                    if (bit_idx_q == c_last_bit) begin
                        state_d = c_par_en ? S_PARITY : S_STOP;
                    end
                end
            end

            S_PARITY: begin
                if (tick_end) begin
                    tick_cnt_d = '0;
                    perr_d     = ((^shift_q) ^ rxd_s_q) != c_par_odd;
                    state_d    = S_STOP;
                end
            end

            S_STOP: begin
                if (tick_end) begin
                    tick_cnt_d = '0;
                    if (c_two_stop && !stop_idx_q) begin
                        stop_idx_d = 1'b1;
                        ferr_d     = ferr_q | ~rxd_s_q;
                    end else begin
                        // Leave at mid-stop so a following start edge is caught
                        done      = 1'b1;
                        done_ferr = ferr_q | ~rxd_s_q;
                        done_perr = perr_q;
                        state_d   = S_IDLE;
                    end
                end
            end

            default: begin
                state_d    = S_IDLE;
                tick_cnt_d = '0;
                bit_idx_d  = '0;
            end
        endcase
    end

    // Receiver FSM registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            tick_cnt_q <= '0;
            bit_idx_q  <= '0;
            shift_q    <= '0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
            stop_idx_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            tick_cnt_q <= tick_cnt_d;
            bit_idx_q  <= bit_idx_d;
            shift_q    <= shift_d;
            perr_q     <= perr_d;
            ferr_q     <= ferr_d;
            stop_idx_q <= stop_idx_d;
        end
    end

    assign fifo_full  = (count_q == c_full_cnt);
    assign fifo_empty = (count_q == '0);
    assign good_char  = done && !done_ferr && !done_perr;
    assign pop        = rd_en && !fifo_empty;
    // A pop in the completion cycle frees the slot the new character needs
    assign push       = good_char && (!fifo_full || rd_en);

    // FIFO storage, pointers and occupancy
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = shift_q;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // FIFO registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Sticky error flags; a new error wins over a simultaneous clear
    always_comb begin
        frame_err_d  = (frame_err_q  & ~err_clr) | (done && done_ferr);
        parity_err_d = (parity_err_q & ~err_clr) | (done && done_perr);
        overrun_d    = (overrun_q    & ~err_clr) | (good_char && fifo_full && !rd_en);
    end

    // Error flag registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_err_q  <= 1'b0;
            parity_err_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            frame_err_q  <= frame_err_d;
            parity_err_q <= parity_err_d;
            overrun_q    <= overrun_d;
        end
    end

    assign rd_data    = mem_q[rd_ptr_q];
    assign rx_empty   = fifo_empty;
    assign rx_count   = count_q;
    assign rx_busy    = (state_q != S_IDLE);
    assign frame_err  = frame_err_q;
    assign parity_err = parity_err_q;
    assign overrun    = overrun_q;

endmodule
`default_nettype wire
